bp_fe_queue_buffer: RTL and testbench

- FE-side queue that produces the fe_queue stream the backend consumes.
- Accepts fetch packets from the FE pc-gen and presents them in order to the BE.
- Honours the BE's speculative-dequeue controls: yumi is a speculative read, deq commits one entry, roll replays uncommitted entries, clr flushes.
- Sits between bp_fe_pc_gen and the BE checker inside the FE top.

---
 rtl/bp_fe_queue_buffer_pkg.sv | 19 +
 rtl/bp_fe_queue_buffer_ptr.sv | 38 +++
 rtl/bp_fe_queue_buffer.sv | 114 +++++++++++
 tb/tb_bp_fe_queue_buffer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_queue_buffer_pkg.sv
// Shared definitions for the FE queue buffer: default sizing, pointer-width helper
// and the per-cycle pointer update mode.
package bp_fe_queue_buffer_pkg;

    localparam int unsigned FE_QUEUE_ELS_DEF   = 8;
    localparam int unsigned FE_QUEUE_WIDTH_DEF = 64;

    // Index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned els);
        return $clog2((els > 1) ? els : 2) + 1;
    endfunction

    typedef enum logic [1:0] {
        Q_NORMAL = 2'd0,
        Q_ROLL   = 2'd1,
        Q_CLR    = 2'd2
    } q_mode_e;

endpackage

// File: rtl/bp_fe_queue_buffer_ptr.sv
// One circular queue pointer (index plus wrap bit); a set takes priority over an increment.
module bp_fe_queue_buffer_ptr
    import bp_fe_queue_buffer_pkg::*;
#(
    parameter int unsigned ptr_width_p = 4
)
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   incr_i,
    input  logic                   set_i,
    input  logic [ptr_width_p-1:0] set_val_i,
    output logic [ptr_width_p-1:0] ptr_o
);

    logic [ptr_width_p-1:0] ptr_q;
    logic [ptr_width_p-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (set_i) begin
            ptr_d = set_val_i;
        end else if (incr_i) begin
            ptr_d = ptr_q + ptr_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_fe_queue_buffer.sv
// FE-side fetch queue with speculative read (yumi), commit (deq), replay (roll)
// and flush (clr) controls from the backend.
module bp_fe_queue_buffer
    import bp_fe_queue_buffer_pkg::*;
#(
    parameter int unsigned els_p         = FE_QUEUE_ELS_DEF,
    parameter int unsigned entry_width_p = FE_QUEUE_WIDTH_DEF
)
(
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic [entry_width_p-1:0] fe_queue_i,
    input  logic                     fe_queue_v_i,
    output logic                     fe_queue_ready_o,

    output logic [entry_width_p-1:0] fe_queue_o,
    output logic                     fe_queue_v_o,
    input  logic                     fe_queue_yumi_i,
    input  logic                     fe_queue_deq_i,
    input  logic                     fe_queue_roll_i,
    input  logic                     fe_queue_clr_i,

    output logic                     empty_o
);

    localparam int unsigned ptr_width_lp = ptr_width(els_p);
    localparam int unsigned idx_width_lp = ptr_width_lp - 1;

    logic [ptr_width_lp-1:0] wptr;
    logic [ptr_width_lp-1:0] rptr;
    logic [ptr_width_lp-1:0] cptr;
    logic [ptr_width_lp-1:0] cptr_adv;
    logic [ptr_width_lp-1:0] rptr_set_val;

    q_mode_e mode;
    logic    full;
    logic    enq;
    logic    deq_eff;

    logic [entry_width_p-1:0] mem_q [els_p];

    always_comb begin
        mode = Q_NORMAL;
        if (fe_queue_clr_i) begin
            mode = Q_CLR;
        end else if (fe_queue_roll_i) begin
            mode = Q_ROLL;
        end
    end

    // Ready looks only at registered pointers, so a same-cycle deq cannot admit a write.
    assign full = (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0])
                & (wptr[idx_width_lp] != cptr[idx_width_lp]);

    assign fe_queue_ready_o = ~full;
    assign fe_queue_v_o     = (rptr != wptr);
    assign empty_o          = (wptr == cptr);

    assign enq     = fe_queue_v_i & fe_queue_ready_o & (mode != Q_CLR);
    assign deq_eff = fe_queue_deq_i & (mode != Q_CLR);

    // Roll lands the read pointer on the commit pointer after this cycle's deq.
    assign cptr_adv     = cptr + ptr_width_lp'(fe_queue_deq_i);
    assign rptr_set_val = (mode == Q_CLR) ? wptr : cptr_adv;

    bp_fe_queue_buffer_ptr #(
        .ptr_width_p (ptr_width_lp)
    ) u_wptr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .incr_i    (enq),
        .set_i     (1'b0),
        .set_val_i ('0),
        .ptr_o     (wptr)
    );

    bp_fe_queue_buffer_ptr #(
        .ptr_width_p (ptr_width_lp)
    ) u_rptr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .incr_i    (fe_queue_yumi_i),
        .set_i     (mode != Q_NORMAL),
        .set_val_i (rptr_set_val),
        .ptr_o     (rptr)
    );

    bp_fe_queue_buffer_ptr #(
        .ptr_width_p (ptr_width_lp)
    ) u_cptr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .incr_i    (deq_eff),
        .set_i     (mode == Q_CLR),
        .set_val_i (wptr),
        .ptr_o     (cptr)
    );

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr[idx_width_lp-1:0]] <= fe_queue_i;
        end
    end

    assign fe_queue_o = mem_q[rptr[idx_width_lp-1:0]];

    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_i) fe_queue_yumi_i |-> fe_queue_v_o);

    a_deq_needs_read: assert property (
        @(posedge clk_i) disable iff (!reset_i) fe_queue_deq_i |-> (cptr != rptr));

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Randomized scoreboard bench for bp_fe_queue_buffer against a queue-based reference model.
module tb_bp_fe_queue_buffer;

    localparam int unsigned ELS    = 4;
    localparam int unsigned W      = 16;
    localparam int unsigned CYCLES = 3000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] fe_queue_i = '0;
    logic         fe_queue_v_i = 1'b0;
    logic         fe_queue_ready_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i = 1'b0;
    logic         fe_queue_deq_i = 1'b0;
    logic         fe_queue_roll_i = 1'b0;
    logic         fe_queue_clr_i = 1'b0;
    logic         empty_o;

    bp_fe_queue_buffer #(
        .els_p         (ELS),
        .entry_width_p (W)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_n),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .fe_queue_deq_i   (fe_queue_deq_i),
        .fe_queue_roll_i  (fe_queue_roll_i),
        .fe_queue_clr_i   (fe_queue_clr_i),
        .empty_o          (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         ready;
        logic         empty;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_q[$];   // uncommitted entries, oldest first
    int unsigned  nread = 0;    // entries speculatively read beyond the commit point
    logic         pending = 1'b0;
    logic [W-1:0] pending_data = '0;
    int           compared = 0;
    int           mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.v     = (nread < model_q.size());
        e.ready = (model_q.size() < ELS);
        e.empty = (model_q.size() == 0);
        e.data  = e.v ? model_q[nread] : '0;
        exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        fe_queue_deq_i  = 1'b0;
        fe_queue_roll_i = 1'b0;
        fe_queue_clr_i  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_v_o"},     32'(fe_queue_v_o),     32'(1'b0));
        check({tag, "_ready_o"}, 32'(fe_queue_ready_o), 32'(1'b1));
        check({tag, "_empty_o"}, 32'(empty_o),          32'(1'b1));
    endtask

    // Monitor: pops one expectation per cycle and compares against the registered outputs.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("v_o",     32'(fe_queue_v_o),     32'(e.v));
                check("ready_o", 32'(fe_queue_ready_o), 32'(e.ready));
                check("empty_o", 32'(empty_o),          32'(e.empty));
                if (e.v) begin
                    check("fe_queue_o", 32'(fe_queue_o), 32'(e.data));
                end
            end
        end
    end

    initial begin : driver
        int unsigned p_v, p_yumi, p_deq, p_roll, p_clr;
        logic yumi, deq, roll, clr, enq, ready;

        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("init");
        reset_n = 1'b1;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            #1;

            if (cyc == 1500 || cyc == 2600) begin
                drive_idle();
                reset_n = 1'b0;
                #1;
                check_reset_state("async_rst");
                model_q.delete();
                nread   = 0;
                pending = 1'b0;
                push_expect();
                continue;
            end
            reset_n = 1'b1;

            push_expect();

            case ((cyc / 100) % 4)
                0:       begin p_v = 90; p_yumi = 30; p_deq = 20; p_roll = 3;  p_clr = 1; end
                1:       begin p_v = 20; p_yumi = 80; p_deq = 70; p_roll = 3;  p_clr = 1; end
                2:       begin p_v = 60; p_yumi = 60; p_deq = 50; p_roll = 5;  p_clr = 2; end
                default: begin p_v = 70; p_yumi = 70; p_deq = 40; p_roll = 15; p_clr = 5; end
            endcase

            if (!pending && ($urandom_range(99) < p_v)) begin
                pending      = 1'b1;
                pending_data = W'($urandom);
            end
            clr   = ($urandom_range(99) < p_clr);
            roll  = !clr && ($urandom_range(99) < p_roll);
            yumi  = (nread < model_q.size()) && ($urandom_range(99) < p_yumi);
            deq   = (nread > 0) && ($urandom_range(99) < p_deq);
            ready = (model_q.size() < ELS);
            enq   = pending && ready && !clr;

            fe_queue_v_i    = pending;
            fe_queue_i      = pending_data;
            fe_queue_yumi_i = yumi;
            fe_queue_deq_i  = deq;
            fe_queue_roll_i = roll;
            fe_queue_clr_i  = clr;

            if (clr) begin
                model_q.delete();
                nread   = 0;
                pending = 1'b0;
            end else begin
                if (roll) begin
                    if (deq) void'(model_q.pop_front());
                    nread = 0;
                end else begin
                    if (yumi) nread++;
                    if (deq) begin
                        void'(model_q.pop_front());
                        nread--;
                    end
                end
                if (enq) begin
                    model_q.push_back(pending_data);
                    pending = 1'b0;
                end
            end
        end

        @(negedge clk);
        drive_idle();
        #5;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
